vector_checker: RTL
===================

# vector_checker

- Synthesizable, parametrised vector player and checker for on-chip self-test of small sequential cores (rpncalc, cpu GPIO path).
- Holds a loadable vector RAM and drives each stimulus word into the DUT. After a programmable settle window it compares the DUT response against the expected word under a mask.
- Counts mismatches, captures the first failure, and can stop on the first error.
- Runs on the slow check clock clk2, alongside the DUT clock domain.

## Interface
- STIM_W, 22: stimulus width (e.g. mode 2 + key 4 + val 16).
- RESP_W, 40: response width (e.g. top 16 + next 16 + counter 8).
- DEPTH, 150: number of vector RAM entries.
- SETTLE, 6: settle cycles per vector, legal range 1..255.
- ERR_W, 16: error counter width (saturating).
- AW, $clog2(DEPTH): vector index width.
- clk2  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- ld_we  in  1  vector RAM write enable.
- ld_addr  in  AW  vector RAM write address.
- ld_data  in  1+STIM_W+RESP_W  vector word {chk, stim, exp}.
- num_vec  in  AW+1  number of vectors to run; values above DEPTH are clamped to DEPTH.
- start  in  1  run request; sampled in IDLE or DONE.
- stop_on_err  in  1  end the run at the first counted mismatch.
- resp_mask  in  RESP_W  global compare mask; 1 means the bit is compared.
- resp  in  RESP_W  DUT response.
- stim  out  STIM_W  registered stimulus to the DUT.
- busy  out  1  run in progress.
- done  out  1  run finished; held until the next start or reset.
- pass  out  1  valid with done; 1 when err_cnt==0.
- vec_idx  out  AW  index of the current or last vector.
- err_cnt  out  ERR_W  counted mismatches, saturating.
- first_err_valid  out  1  a first error has been captured.
- first_err_idx  out  AW  index of the first counted mismatch.
- first_err_resp  out  RESP_W  raw resp at the first counted mismatch.

## Operation
- States: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE/DONE with start=1:
  - If effective num_vec==0: go to DONE with pass=1 and err_cnt=0.
  - Otherwise: clear err_cnt, first_err_*, done and pass; set vec_idx=0, busy=1; go to APPLY.
- APPLY (1 cycle): stim and the internal exp/chk registers load from RAM[vec_idx]. Go to SETTLE with settle counter =0.
- SETTLE: the counter increments each cycle. After SETTLE cycles, go to CHECK.
- CHECK (1 cycle): the vector mismatches when chk=1 and ((resp ^ exp) & resp_mask) != 0.
  - On a mismatch: err_cnt increments, saturating at all-ones. If first_err_valid=0, capture vec_idx and resp and set first_err_valid.
  - End of run (last vector, or mismatch with stop_on_err=1): go to DONE and set done=1, busy=0, pass=(err_cnt_next==0). vec_idx holds.
  - Otherwise: vec_idx increments and the block returns to APPLY.
- chk=0 vectors are applied to the DUT but never counted; they act as idle/setup steps.
- stim holds its last value in DONE and IDLE.
- ld_we is ignored while busy=1. start is ignored while busy=1.
- Reset values of all outputs and state: state=IDLE, stim=0, busy=0, done=0, pass=0, vec_idx=0, err_cnt=0, first_err_valid=0, first_err_idx=0, first_err_resp=0. RAM contents are not reset.

## Timing
- Vector RAM has a synchronous write and a synchronous read. Its read address is the next-state vec_idx, so the read data is valid during APPLY.
- Each vector takes SETTLE+2 cycles: APPLY 1, SETTLE SETTLE, CHECK 1.
- stim changes on the edge that leaves APPLY.
- resp is sampled on the edge that leaves CHECK, i.e. SETTLE+1 edges after stim changed.
- done rises N*(SETTLE+2) edges after the start edge. With stop_on_err=1 and a failure at index k, done rises (k+1)*(SETTLE+2) edges after start.
- A RAM write and a read of the same address in the same cycle returns the old data. This case cannot occur, because writes are blocked while busy.
- rst=0 at any state, including mid-SETTLE, returns everything to reset values on that edge. A start sampled on the same edge is discarded.

## Structure
- vecchk_pkg:
  - state enum typedef.
  - Field offset localparams for {chk, stim, exp} as functions of STIM_W/RESP_W.
  - Clamp function for num_vec.
- Sub-module vector_ram (DEPTH x (1+STIM_W+RESP_W), one write port, one synchronous read port). The top FSM, counters and compare logic stay in vector_checker.

## Test plan
Bench ties resp = {18'h0, stim} (defaults, SETTLE=6, resp_mask all ones).
1. Three vectors, chk=1, exp = zero-extended stim (e.g. stim 22'h0C_1234) -> done after 24 cycles, pass=1, err_cnt=0, vec_idx=2.
2. Same, but vector 1 exp has bit 0 flipped, stop_on_err=0 -> all 3 run, err_cnt=1, first_err_idx=1, first_err_resp = vector 1 resp, pass=0.
3. Scenario 2 with stop_on_err=1 -> done after 16 cycles, vec_idx=1. Then start again after fixing vector 1 via ld_we -> pass=1, first_err_valid=0.
4. Masking:
   - Mismatching vector with chk=0 -> err_cnt=0.
   - Mismatch on bit 0 only, with resp_mask bit 0 cleared -> err_cnt=0.
5. Boundary cases:
   - num_vec=0 -> done next edge, pass=1.
   - num_vec=200 -> 150 vectors run.
   - ERR_W=4 with 150 failing vectors -> err_cnt=15 (saturated).
6. Reset and blocking:
   - rst=0 for one edge mid-SETTLE of vector 2 -> all outputs at reset values next edge, stim=0.
   - start and ld_we pulsed while busy -> no effect on the run or RAM contents.

Source files
------------

// File: rtl/vecchk_pkg.sv
// vector_checker shared types, vector-word layout and helpers.
// Word layout is {chk, stim, exp} with exp in the low bits.
package vecchk_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_e;

  function automatic int unsigned exp_lsb();
    return 0;
  endfunction

  function automatic int unsigned stim_lsb(int unsigned resp_w);
    return resp_w;
  endfunction

  function automatic int unsigned chk_pos(int unsigned stim_w,
                                          int unsigned resp_w);
    return stim_w + resp_w;
  endfunction

  localparam int unsigned STIM_W_DEF = 22;
  localparam int unsigned RESP_W_DEF = 40;
  localparam int unsigned EXP_LSB_DEF = exp_lsb();
  localparam int unsigned STIM_LSB_DEF = stim_lsb(RESP_W_DEF);
  localparam int unsigned CHK_POS_DEF = chk_pos(STIM_W_DEF, RESP_W_DEF);

  function automatic int unsigned clamp_nv(int unsigned nv,
                                           int unsigned depth);
    return (nv > depth) ? depth : nv;
  endfunction

endpackage

// File: rtl/vector_checker_if.sv
// Load, control, DUT-facing and status bundle of the vector checker.
// master = controller/bench side, slave = checker side.
interface vector_checker_if #(
  parameter int STIM_W = 22,
  parameter int RESP_W = 40,
  parameter int DEPTH  = 150,
  parameter int ERR_W  = 16,
  parameter int AW     = $clog2(DEPTH)
);
  localparam int WW = 1 + STIM_W + RESP_W;

  logic              ld_we;
  logic [AW-1:0]     ld_addr;
  logic [WW-1:0]     ld_data;
  logic [AW:0]       num_vec;
  logic              start;
  logic              stop_on_err;
  logic [RESP_W-1:0] resp_mask;
  logic [RESP_W-1:0] resp;
  logic [STIM_W-1:0] stim;
  logic              busy;
  logic              done;
  logic              pass;
  logic [AW-1:0]     vec_idx;
  logic [ERR_W-1:0]  err_cnt;
  logic              first_err_valid;
  logic [AW-1:0]     first_err_idx;
  logic [RESP_W-1:0] first_err_resp;

  modport master (
    output ld_we, ld_addr, ld_data, num_vec, start,
    output stop_on_err, resp_mask, resp,
    input  stim, busy, done, pass, vec_idx, err_cnt,
    input  first_err_valid, first_err_idx, first_err_resp
  );

  modport slave (
    input  ld_we, ld_addr, ld_data, num_vec, start,
    input  stop_on_err, resp_mask, resp,
    output stim, busy, done, pass, vec_idx, err_cnt,
    output first_err_valid, first_err_idx, first_err_resp
  );
endinterface

// File: rtl/vector_checker_ram.sv
// Vector store: one synchronous write port, one synchronous read port.
// Same-address write/read returns the old word.
module vector_ram #(
  parameter int DEPTH = 150,
  parameter int W     = 63,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/vector_checker.sv
// Vector player/checker: applies stored stimulus, waits a settle window,
// then compares the masked response and records errors.
module vector_checker
  import vecchk_pkg::*;
#(
  parameter int STIM_W = 22,
  parameter int RESP_W = 40,
  parameter int DEPTH  = 150,
  parameter int SETTLE = 6,
  parameter int ERR_W  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input logic             clk2,
  input logic             rst,
  vector_checker_if.slave bus
);
  localparam int WW = 1 + STIM_W + RESP_W;
  localparam int NW = AW + 1;
  localparam int EXP_L = exp_lsb();
  localparam int STIM_L = stim_lsb(RESP_W);
  localparam int CHK_P = chk_pos(STIM_W, RESP_W);

  state_e            state_q, state_d;
  logic [STIM_W-1:0] stim_q, stim_d;
  logic [RESP_W-1:0] exp_q, exp_d;
  logic              chk_q, chk_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              fev_q, fev_d;
  logic [AW-1:0]     fei_q, fei_d;
  logic [RESP_W-1:0] fer_q, fer_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [NW-1:0]     nv_q, nv_d;

  logic [WW-1:0]     rd_data;
  logic [NW-1:0]     nv_clamp;
  logic              mis;
  logic              last;

  vector_ram #(
    .DEPTH (DEPTH),
    .W     (WW),
    .AW    (AW)
  ) u_ram (
    .clk     (clk2),
    .we_i    (bus.ld_we & ~busy_q),
    .waddr_i (bus.ld_addr),
    .wdata_i (bus.ld_data),
    .raddr_i (idx_d),
    .rdata_o (rd_data)
  );

  assign nv_clamp = NW'(clamp_nv(int'(bus.num_vec), DEPTH));
  assign mis = chk_q & (|((bus.resp ^ exp_q) & bus.resp_mask));
  assign last = (NW'(idx_q) + NW'(1)) == nv_q;

  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    exp_d   = exp_q;
    chk_d   = chk_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    idx_d   = idx_q;
    err_d   = err_q;
    fev_d   = fev_q;
    fei_d   = fei_q;
    fer_d   = fer_q;
    cnt_d   = cnt_q;
    nv_d    = nv_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          err_d = '0;
          fev_d = 1'b0;
          fei_d = '0;
          fer_d = '0;
          if (nv_clamp == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_APPLY;
            nv_d    = nv_clamp;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            idx_d   = '0;
            busy_d  = 1'b1;
          end
        end
      end
      S_APPLY: begin
        stim_d  = rd_data[STIM_L +: STIM_W];
        exp_d   = rd_data[EXP_L +: RESP_W];
        chk_d   = rd_data[CHK_P];
        cnt_d   = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'(SETTLE - 1)) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (mis) begin
          err_d = (&err_q) ? err_q : err_q + ERR_W'(1);
          if (!fev_q) begin
            fev_d = 1'b1;
            fei_d = idx_q;
            fer_d = bus.resp;
          end
        end
        if (last || (mis && bus.stop_on_err)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          pass_d  = (err_d == '0);
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = S_APPLY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk2) begin
    if (!rst) begin
      state_q <= S_IDLE;
      stim_q  <= '0;
      exp_q   <= '0;
      chk_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      idx_q   <= '0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fei_q   <= '0;
      fer_q   <= '0;
      cnt_q   <= '0;
      nv_q    <= '0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      exp_q   <= exp_d;
      chk_q   <= chk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      fev_q   <= fev_d;
      fei_q   <= fei_d;
      fer_q   <= fer_d;
      cnt_q   <= cnt_d;
      nv_q    <= nv_d;
    end
  end

  assign bus.stim            = stim_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.pass            = pass_q;
  assign bus.vec_idx         = idx_q;
  assign bus.err_cnt         = err_q;
  assign bus.first_err_valid = fev_q;
  assign bus.first_err_idx   = fei_q;
  assign bus.first_err_resp  = fer_q;
endmodule
